// File: rtl/cyl_pkg.sv
// Shared constants and state type for the rectangular-to-cylindrical CORDIC pipe.
// Imported by the operand loader and by the CORDIC core.
package cyl_pkg;

   localparam int unsigned DATA_W = 8;

   // Two's complement extremes: SMIN is the only value whose negation overflows
   localparam logic signed [DATA_W-1:0] SMIN     = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] SMAX_NEG = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_X    = 2'd0,
      S_Y    = 2'd1,
      S_Z    = 2'd2,
      S_HOLD = 2'd3
   } ld_state_t;

endpackage : cyl_pkg

// File: rtl/cyl_operand_loader_strobe_sync_edge.sv
// Synchronizes an asynchronous pin strobe and emits a one-clock pulse per rising edge.
// The pulse is combinational from the last sync flop and the edge register.
module strobe_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic cap_c
);

   localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Synchronizer chain plus edge-history register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign cap_c = sync_q[STAGES-1] & ~prev_q;

endmodule : strobe_sync_edge

// File: rtl/cyl_operand_loader.sv
// Byte-serial x/y/z operand loader: assembles a triple, folds x/y into the right
// half-plane with -128 clamping, and offers it to the CORDIC core over valid/ready.
module cyl_operand_loader
   import cyl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_stb,
   input  logic              frame_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] x_out,
   output logic [DATA_W-1:0] y_out,
   output logic [DATA_W-1:0] z_out,
   output logic              flip_out,
   output logic              busy,
   output logic              err_ovr
);

   ld_state_t state;

   logic signed [DATA_W-1:0] raw_x;
   logic signed [DATA_W-1:0] raw_y;

   logic cap_c;
   logic take_c;
   logic xfer_c;

   logic signed [DATA_W-1:0] byte_s_c;
   logic signed [DATA_W-1:0] xc_c;
   logic signed [DATA_W-1:0] yc_c;
   logic signed [DATA_W-1:0] zc_c;
   logic signed [DATA_W-1:0] x_fold_c;
   logic signed [DATA_W-1:0] y_fold_c;
   logic                     flip_c;

   strobe_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (byte_stb),
      .cap_c    (cap_c)
   );

   assign take_c = cap_c & ena;
   assign xfer_c = out_valid & out_ready;

   // Clamp then fold; z is folded straight from the third byte as it arrives
   always_comb begin
      byte_s_c = byte_in;
      xc_c     = (raw_x == SMIN) ? SMAX_NEG : raw_x;
      yc_c     = (raw_y == SMIN) ? SMAX_NEG : raw_y;
      zc_c     = (byte_s_c == SMIN) ? SMAX_NEG : byte_s_c;
      flip_c   = xc_c[DATA_W-1];
      x_fold_c = xc_c;
      y_fold_c = yc_c;
      if (flip_c) begin
         x_fold_c = -xc_c;
         y_fold_c = -yc_c;
      end
   end

   // Frame FSM with registered outputs; frame_clr overrides captures and transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_X;
         raw_x     <= '0;
         raw_y     <= '0;
         out_valid <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         z_out     <= '0;
         flip_out  <= 1'b0;
         busy      <= 1'b0;
         err_ovr   <= 1'b0;
      end else if (frame_clr) begin
         state     <= S_X;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err_ovr   <= 1'b0;
      end else begin
         unique case (state)
            S_X: begin
               if (take_c) begin
                  raw_x <= byte_in;
                  state <= S_Y;
                  busy  <= 1'b1;
               end
            end
            S_Y: begin
               if (take_c) begin
                  raw_y <= byte_in;
                  state <= S_Z;
               end
            end
            S_Z: begin
               if (take_c) begin
                  state     <= S_HOLD;
                  out_valid <= 1'b1;
                  x_out     <= x_fold_c;
                  y_out     <= y_fold_c;
                  z_out     <= zc_c;
                  flip_out  <= flip_c;
               end
            end
            S_HOLD: begin
               if (xfer_c) begin
                  out_valid <= 1'b0;
                  // A byte landing in the transfer cycle starts the next frame
                  if (take_c) begin
                     raw_x <= byte_in;
                     state <= S_Y;
                  end else begin
                     state <= S_X;
                     busy  <= 1'b0;
                  end
               end else if (take_c) begin
                  err_ovr <= 1'b1;
               end
            end
            default: begin
               state     <= S_X;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule : cyl_operand_loader

// File: tb/tb_cyl_operand_loader.sv
// Directed bench for cyl_operand_loader: expected triples queued at stimulus time,
// popped and compared by a monitor on every accepted handshake.
module tb_cyl_operand_loader;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] byte_in;
   logic       byte_stb;
   logic       frame_clr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] x_out;
   logic [7:0] y_out;
   logic [7:0] z_out;
   logic       flip_out;
   logic       busy;
   logic       err_ovr;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
      logic       flip;
   } exp_t;

   exp_t sb[$];
   int   total;
   int   bad;
   int   xfer_cnt;

   cyl_operand_loader #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .byte_in   (byte_in),
      .byte_stb  (byte_stb),
      .frame_clr (frame_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out),
      .flip_out  (flip_out),
      .busy      (busy),
      .err_ovr   (err_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                       input logic flip);
      exp_t e;
      e.x = x; e.y = y; e.z = z; e.flip = flip;
      sb.push_back(e);
   endtask

   // Called at posedge+2; returns at posedge+2
   task automatic send_byte(input logic [7:0] b);
      byte_in  = b;
      byte_stb = 1'b1;
      repeat (4) @(posedge clk);
      #2 byte_stb = 1'b0;
      repeat (4) @(posedge clk);
      #2;
   endtask

   // Scoreboard monitor: one pop per accepted triple
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         exp_t e;
         xfer_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected actual=%0h/%0h/%0h required=none", x_out, y_out, z_out);
         end else begin
            e = sb.pop_front();
            chk("sb_x", 32'(x_out), 32'(e.x));
            chk("sb_y", 32'(y_out), 32'(e.y));
            chk("sb_z", 32'(z_out), 32'(e.z));
            chk("sb_flip", 32'(flip_out), 32'(e.flip));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      total = 0; bad = 0; xfer_cnt = 0;
      rst_n = 1'b0; ena = 1'b1; byte_in = 8'h00; byte_stb = 1'b0;
      frame_clr = 1'b0; out_ready = 1'b0;

      // 1. Reset with strobe toggling
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2 byte_stb = ~byte_stb;
      end
      byte_stb = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_x", 32'(x_out), 32'd0);
      chk("rst_flip", 32'(flip_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_ovr), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_busy", 32'(busy), 32'd0);
         #1;
      end

      // 2. Plain frame with latency check on the third byte
      out_ready = 1'b1;
      push(8'd30, 8'd40, 8'd5, 1'b0);
      n0 = xfer_cnt;
      send_byte(8'd30);
      send_byte(8'd40);
      byte_in = 8'd5; byte_stb = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("lat_pre_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      chk("lat_post_valid", 32'(out_valid), 32'd0);
      chk("lat_post_busy", 32'(busy), 32'd0);
      #1 byte_stb = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("single_xfer", 32'(xfer_cnt - n0), 32'd1);

      // 3. Fold and clamp
      push(8'd127, 8'hEC, 8'h81, 1'b1);
      send_byte(8'h80); send_byte(8'd20); send_byte(8'h80);
      push(8'd50, 8'd60, 8'd0, 1'b1);
      send_byte(8'hCE); send_byte(8'hC4); send_byte(8'd0);

      // 4. Backpressure and overrun
      out_ready = 1'b0;
      push(8'd10, 8'd20, 8'd30, 1'b0);
      send_byte(8'd10); send_byte(8'd20); send_byte(8'd30);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_err0", 32'(err_ovr), 32'd0);
      send_byte(8'd99);
      chk("ovr_valid", 32'(out_valid), 32'd1);
      chk("ovr_err", 32'(err_ovr), 32'd1);
      chk("ovr_x", 32'(x_out), 32'd10);
      chk("ovr_y", 32'(y_out), 32'd20);
      chk("ovr_z", 32'(z_out), 32'd30);
      n0 = xfer_cnt;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("ovr_one_xfer", 32'(xfer_cnt - n0), 32'd1);
      chk("ovr_err_sticky", 32'(err_ovr), 32'd1);
      chk("ovr_busy", 32'(busy), 32'd0);
      frame_clr = 1'b1;
      @(posedge clk); #2 frame_clr = 1'b0;
      chk("clr_err", 32'(err_ovr), 32'd0);

      // 5. Cap lands exactly in the transfer cycle
      out_ready = 1'b0;
      push(8'd11, 8'd12, 8'd13, 1'b0);
      send_byte(8'd11); send_byte(8'd12); send_byte(8'd13);
      push(8'd77, 8'd88, 8'd99, 1'b0);
      byte_in = 8'd77; byte_stb = 1'b1;
      @(posedge clk); @(posedge clk);
      #2 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("sim_valid", 32'(out_valid), 32'd0);
      chk("sim_busy", 32'(busy), 32'd1);
      chk("sim_err", 32'(err_ovr), 32'd0);
      #1;
      @(posedge clk); #2 byte_stb = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      send_byte(8'd88); send_byte(8'd99);

      // 6. Abort, ena gating, reset in S_HOLD
      send_byte(8'd5); send_byte(8'd6);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      frame_clr = 1'b1;
      @(posedge clk); #2 frame_clr = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      push(8'd1, 8'd2, 8'd3, 1'b0);
      send_byte(8'd1);
      ena = 1'b0;
      send_byte(8'd50);
      send_byte(8'd51);
      ena = 1'b1;
      chk("ena_busy", 32'(busy), 32'd1);
      send_byte(8'd2); send_byte(8'd3);
      out_ready = 1'b0;
      send_byte(8'd7); send_byte(8'd8); send_byte(8'd9);
      chk("hold_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_x", 32'(x_out), 32'd0);
      chk("rst_hold_busy", 32'(busy), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("xfer_total", 32'(xfer_cnt), 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cyl_operand_loader
